traffic_light_monitor: RTL and testbench

- Independent watchdog that samples the two 2-bit lamp-drive buses from the traffic light controller (`ns`, `ew`) and checks them against the light protocol.
- Checks for: illegal codes, conflicting right-of-way, out-of-order phase changes and too-short green/yellow phases.
- Latches the first violation with a cause code until software clears it.
- While faulted, produces a flash-mode blink strobe for the lamp drivers.

---
 rtl/traffic_light_monitor.sv | 191 +++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: protocol watchdog for the NS/EW lamp buses.
// Latches the first violation and blinks flash_on while faulted.
module traffic_light_monitor #(
  parameter int MIN_GREEN  = 2,
  parameter int MIN_YELLOW = 1,
  parameter int CNT_W      = 8,
  parameter int FLASH_HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ns,
  input  logic [1:0]  ew,
  input  logic        fault_clr,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        fault_dir,
  output logic        flash_on,
  output logic [15:0] cycle_cnt
);

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] GRN = 2'b01;
  localparam logic [1:0] YEL = 2'b10;
  localparam logic [1:0] ILL = 2'b11;

  localparam logic [CNT_W-1:0] DMAX = '1;
  localparam logic [CNT_W-1:0] MING =
    CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MINY =
    CNT_W'(MIN_YELLOW);

  localparam int DW =
    (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(FLASH_HALF - 1);

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_ILL  = 3'd1,
    C_CONF = 3'd2,
    C_SEQ  = 3'd3,
    C_SG   = 3'd4,
    C_SY   = 3'd5
  } cause_t;

  logic [1:0]       ns_prev;
  logic [1:0]       ew_prev;
  logic [CNT_W-1:0] ns_dwell;
  logic [CNT_W-1:0] ew_dwell;
  logic [DW-1:0]    div;

  logic   ns_ill, ew_ill, conf;
  logic   ns_seq, ew_seq;
  logic   ns_sg, ew_sg;
  logic   ns_sy, ew_sy;
  logic   viol;
  cause_t cause;
  logic   vdir;
  logic   fault_d;
  logic [2:0] code_d;
  logic   dir_d;

  // Changes into ILL are reported as illegal only.
  function automatic logic seq_bad(
    input logic [1:0] p,
    input logic [1:0] c
  );
    logic ok;
    ok = (p == RED && c == GRN) ||
         (p == GRN && c == YEL) ||
         (p == YEL && c == RED);
    return (c != p) && (c != ILL) && !ok;
  endfunction

  // Raw per-check violation flags from the old history.
  always_comb begin
    ns_ill = (ns == ILL);
    ew_ill = (ew == ILL);
    conf   = (ns != RED) && (ew != RED);
    ns_seq = seq_bad(ns_prev, ns);
    ew_seq = seq_bad(ew_prev, ew);
    ns_sg  = (ns_prev == GRN) && (ns == YEL) &&
             (ns_dwell < MING);
    ew_sg  = (ew_prev == GRN) && (ew == YEL) &&
             (ew_dwell < MING);
    ns_sy  = (ns_prev == YEL) && (ns == RED) &&
             (ns_dwell < MINY);
    ew_sy  = (ew_prev == YEL) && (ew == RED) &&
             (ew_dwell < MINY);
  end

  // Pick the single highest-priority violation.
  always_comb begin
    cause = C_NONE;
    vdir  = 1'b0;
    priority case (1'b1)
      ns_ill: cause = C_ILL;
      ew_ill: begin cause = C_ILL; vdir = 1'b1; end
      conf:   cause = C_CONF;
      ns_seq: cause = C_SEQ;
      ew_seq: begin cause = C_SEQ; vdir = 1'b1; end
      ns_sg:  cause = C_SG;
      ew_sg:  begin cause = C_SG; vdir = 1'b1; end
      ns_sy:  cause = C_SY;
      ew_sy:  begin cause = C_SY; vdir = 1'b1; end
      default: ;
    endcase
    viol = (cause != C_NONE);
  end

  // Latch next-state: a same-edge violation beats a clear.
  always_comb begin
    fault_d = fault;
    code_d  = fault_code;
    dir_d   = fault_dir;
    if (viol && (!fault || fault_clr)) begin
      fault_d = 1'b1;
      code_d  = cause;
      dir_d   = vdir;
    end else if (fault_clr) begin
      fault_d = 1'b0;
      code_d  = 3'd0;
      dir_d   = 1'b0;
    end
  end

  // Fault latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
      fault_dir  <= 1'b0;
    end else begin
      fault      <= fault_d;
      fault_code <= code_d;
      fault_dir  <= dir_d;
    end
  end

  // Per-direction last code and saturating dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_prev  <= RED;
      ew_prev  <= RED;
      ns_dwell <= '0;
      ew_dwell <= '0;
    end else begin
      if (ns == ns_prev) begin
        if (ns_dwell != DMAX)
          ns_dwell <= ns_dwell + 1'b1;
      end else begin
        ns_prev  <= ns;
        ns_dwell <= CNT_W'(1);
      end
      if (ew == ew_prev) begin
        if (ew_dwell != DMAX)
          ew_dwell <= ew_dwell + 1'b1;
      end else begin
        ew_prev  <= ew;
        ew_dwell <= CNT_W'(1);
      end
    end
  end

  // Blink divider; cleared on the edge the fault drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      flash_on <= 1'b0;
    end else if (!fault || !fault_d) begin
      div      <= '0;
      flash_on <= 1'b0;
    end else if (div == DIV_LAST) begin
      div      <= '0;
      flash_on <= ~flash_on;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Count clean NS yellow-to-red completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= 16'd0;
    end else if (ns_prev == YEL && ns == RED &&
                 !viol && !fault) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed and randomized checks
// of the lamp watchdog against a rule-level model.
module tb_traffic_light_monitor;

  localparam int MG = 2;
  localparam int MY = 1;
  localparam int CW = 8;
  localparam int FH = 4;
  localparam int DMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ns = 2'b00;
  logic [1:0]  ew = 2'b00;
  logic        fault_clr = 1'b0;
  logic        fault;
  logic [2:0]  fault_code;
  logic        fault_dir;
  logic        flash_on;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int failures = 0;

  int m_nsp, m_ewp, m_nsd, m_ewd;
  bit m_fault;
  int m_code, m_dir, m_age, m_cnt;

  traffic_light_monitor #(
    .MIN_GREEN (MG),
    .MIN_YELLOW(MY),
    .CNT_W     (CW),
    .FLASH_HALF(FH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ns        (ns),
    .ew        (ew),
    .fault_clr (fault_clr),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_dir (fault_dir),
    .flash_on  (flash_on),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit seq_bad(int p, int c);
    if (c == p || c == 3) return 1'b0;
    if (p == 0 && c == 1) return 1'b0;
    if (p == 1 && c == 2) return 1'b0;
    if (p == 2 && c == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_flash();
    return m_fault && (((m_age / FH) % 2) == 1);
  endfunction

  task automatic m_reset();
    m_nsp = 0; m_ewp = 0; m_nsd = 0; m_ewd = 0;
    m_fault = 0; m_code = 0; m_dir = 0;
    m_age = 0; m_cnt = 0;
  endtask

  task automatic m_step(input int n, input int e,
                        input bit clr);
    int code;
    int dir;
    code = 0;
    dir = 0;
    if (n == 3) code = 1;
    else if (e == 3) begin code = 1; dir = 1; end
    else if (n != 0 && e != 0) code = 2;
    else if (seq_bad(m_nsp, n)) code = 3;
    else if (seq_bad(m_ewp, e)) begin
      code = 3; dir = 1;
    end
    else if (m_nsp == 1 && n == 2 && m_nsd < MG)
      code = 4;
    else if (m_ewp == 1 && e == 2 && m_ewd < MG) begin
      code = 4; dir = 1;
    end
    else if (m_nsp == 2 && n == 0 && m_nsd < MY)
      code = 5;
    else if (m_ewp == 2 && e == 0 && m_ewd < MY) begin
      code = 5; dir = 1;
    end
    if (m_nsp == 2 && n == 0 && code == 0 && !m_fault)
      m_cnt = (m_cnt + 1) % 65536;
    if (code != 0 && (!m_fault || clr)) begin
      m_age = m_fault ? m_age + 1 : 0;
      m_fault = 1; m_code = code; m_dir = dir;
    end else if (clr) begin
      m_fault = 0; m_code = 0; m_dir = 0; m_age = 0;
    end else if (m_fault) begin
      m_age++;
    end
    if (n == m_nsp) m_nsd = (m_nsd < DMAX) ? m_nsd + 1 : DMAX;
    else begin m_nsp = n; m_nsd = 1; end
    if (e == m_ewp) m_ewd = (m_ewd < DMAX) ? m_ewd + 1 : DMAX;
    else begin m_ewp = e; m_ewd = 1; end
  endtask

  task automatic step(input logic [1:0] n,
                      input logic [1:0] e,
                      input logic clr);
    ns = n;
    ew = e;
    fault_clr = clr;
    @(posedge clk);
    #1;
    m_step(int'(n), int'(e), clr);
    fault_clr = 1'b0;
  endtask

  task automatic do_reset();
    ns = 2'b00; ew = 2'b00; fault_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 ||
        fault_dir !== 1'b0 || flash_on !== 1'b0 ||
        cycle_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_vals got=%b/%0d/%b/%b/%0d exp=0",
               fault, fault_code, fault_dir, flash_on,
               cycle_cnt);
    end
    step(2'd1, 2'd0, 1'b0);
    step(2'd1, 2'd0, 1'b0);
    step(2'd2, 2'd0, 1'b0);
    step(2'd0, 2'd0, 1'b0);
    step(2'd3, 2'd0, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1 ||
        cycle_cnt !== 16'd1) begin
      failures++;
      $display("FAIL pre_reset got=%b/%0d/%0d exp=1/1/1",
               fault, fault_code, cycle_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 ||
        fault_dir !== 1'b0 || flash_on !== 1'b0 ||
        cycle_cnt !== 16'd0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d/%b/%b/%0d exp=0",
               fault, fault_code, fault_dir, flash_on,
               cycle_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 2'd0, 1'b0);
      checks++;
      if (fault !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle i=%0d got=%b exp=0",
                 i, fault);
      end
    end
    do_reset();
    step(2'd0, 2'd1, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL ew_green_first got=%b exp=0", fault);
    end
    step(2'd0, 2'd0, 1'b0);
    step(2'd1, 2'd0, 1'b0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    step(2'd2, 2'd0, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      failures++;
      $display("FAIL history_discard got=%b/%0d exp=1/3",
               fault, fault_code);
    end
  endtask

  task automatic test_legal_cycle();
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(seq[i], 2'd0, 1'b0);
      checks++;
      if (fault !== 1'b0) begin
        failures++;
        $display("FAIL legal_fault i=%0d got=%b exp=0",
                 i, fault);
      end
    end
    checks++;
    if (cycle_cnt !== 16'd1) begin
      failures++;
      $display("FAIL legal_cnt got=%0d exp=1", cycle_cnt);
    end
  endtask

  task automatic test_conflict_flash();
    bit exp;
    do_reset();
    step(2'd1, 2'd1, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2 ||
        fault_dir !== 1'b0 || flash_on !== 1'b0) begin
      failures++;
      $display("FAIL conflict got=%b/%0d/%b/%b exp=1/2/0/0",
               fault, fault_code, fault_dir, flash_on);
    end
    for (int i = 1; i <= 13; i++) begin
      step(2'd0, 2'd0, 1'b0);
      exp = ((i / 4) % 2) == 1;
      checks++;
      if (flash_on !== exp || flash_on !== m_flash()) begin
        failures++;
        $display("FAIL flash i=%0d got=%b exp=%b",
                 i, flash_on, exp);
      end
    end
    checks++;
    if (fault_code !== 3'd2) begin
      failures++;
      $display("FAIL conflict_hold got=%0d exp=2",
               fault_code);
    end
  endtask

  task automatic test_short_green();
    do_reset();
    step(2'd1, 2'd0, 1'b0);
    step(2'd2, 2'd0, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4 ||
        fault_dir !== 1'b0) begin
      failures++;
      $display("FAIL short_green got=%b/%0d/%b exp=1/4/0",
               fault, fault_code, fault_dir);
    end
    step(2'd2, 2'd3, 1'b0);
    checks++;
    if (fault_code !== 3'd4 || fault_dir !== 1'b0) begin
      failures++;
      $display("FAIL sg_hold got=%0d/%b exp=4/0",
               fault_code, fault_dir);
    end
  endtask

  task automatic test_illegal_priority();
    do_reset();
    step(2'd1, 2'd3, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1 ||
        fault_dir !== 1'b1) begin
      failures++;
      $display("FAIL ill_prio got=%b/%0d/%b exp=1/1/1",
               fault, fault_code, fault_dir);
    end
  endtask

  task automatic test_short_yellow_ew();
    do_reset();
    step(2'd0, 2'd1, 1'b0);
    step(2'd0, 2'd1, 1'b0);
    step(2'd0, 2'd2, 1'b0);
    step(2'd0, 2'd0, 1'b0);
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL ew_legal got=%b exp=0", fault);
    end
    step(2'd0, 2'd2, 1'b0);
    checks++;
    if (fault_code !== 3'd3 || fault_dir !== 1'b1) begin
      failures++;
      $display("FAIL ew_seq got=%0d/%b exp=3/1",
               fault_code, fault_dir);
    end
  endtask

  task automatic test_clear();
    do_reset();
    step(2'd1, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) step(2'd0, 2'd0, 1'b0);
    step(2'd0, 2'd0, 1'b1);
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 ||
        fault_dir !== 1'b0 || flash_on !== 1'b0) begin
      failures++;
      $display("FAIL clear got=%b/%0d/%b/%b exp=0/0/0/0",
               fault, fault_code, fault_dir, flash_on);
    end
    step(2'd1, 2'd1, 1'b0);
    step(2'd0, 2'd0, 1'b1);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3 ||
        fault_dir !== 1'b0) begin
      failures++;
      $display("FAIL clr_vs_viol got=%b/%0d/%b exp=1/3/0",
               fault, fault_code, fault_dir);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) step(2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 300; i++) step(2'd1, 2'd0, 1'b0);
    step(2'd2, 2'd0, 1'b0);
    step(2'd0, 2'd0, 1'b0);
    checks++;
    if (fault !== 1'b0 || cycle_cnt !== 16'd1) begin
      failures++;
      $display("FAIL saturate got=%b/%0d exp=0/1",
               fault, cycle_cnt);
    end
  endtask

  task automatic test_random();
    logic [1:0] n, e;
    logic c;
    int r;
    int shown;
    do_reset();
    n = 2'd0;
    e = 2'd0;
    shown = 0;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35) n = (n == 2'd2) ? 2'd0 : n + 2'd1;
      else if (r < 38) n = 2'($urandom_range(0, 3));
      if (n == 2'd0) begin
        r = int'($urandom_range(0, 99));
        if (r < 35) e = (e == 2'd2) ? 2'd0 : e + 2'd1;
        else if (r < 37) e = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 99) < 95) begin
        e = 2'd0;
      end
      c = ($urandom_range(0, 99) < 6);
      step(n, e, c);
      checks++;
      if (fault !== m_fault ||
          fault_code !== 3'(m_code) ||
          fault_dir !== 1'(m_dir) ||
          flash_on !== m_flash() ||
          cycle_cnt !== 16'(m_cnt)) begin
        failures++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand i=%0d got=%b/%0d/%b/%b/%0d exp=%b/%0d/%0d/%b/%0d",
                   i, fault, fault_code, fault_dir,
                   flash_on, cycle_cnt, m_fault, m_code,
                   m_dir, m_flash(), m_cnt);
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_legal_cycle();
    test_conflict_flash();
    test_short_green();
    test_illegal_priority();
    test_short_yellow_ew();
    test_clear();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
